// File: rtl/joint_pwm_ctrl.sv
// Joint PWM sequencer: clamps and slew-limits the host duty command and inserts
// dead time on direction reversal. A stall supervisor latches a fault when the
// joint is driven hard but the encoder does not move.
module joint_pwm_ctrl #(
    parameter int unsigned UPDATE_DIV  = 1000,
    parameter int unsigned SLEW_STEP   = 100,
    parameter int unsigned DUTY_MAX    = 100000,
    parameter int unsigned DEADTIME    = 5000,
    parameter int unsigned STALL_MIN   = 20000,
    parameter int unsigned STALL_TICKS = 1000,
    parameter int unsigned ENC_BITS    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable_in,
    input  logic signed [31:0]  cmd,
    input  logic [ENC_BITS-1:0] enc_pos,
    output logic signed [31:0]  duty_out,
    output logic                joint_enable,
    output logic                fault,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDead  = 2'd2,
        StFault = 2'd3
    } state_e;

    // Direction codes for last_dir and signs of target/duty
    localparam logic [1:0] DirNone = 2'b00;
    localparam logic [1:0] DirPos  = 2'b01;
    localparam logic [1:0] DirNeg  = 2'b10;

    localparam logic signed [32:0] DutyMax33 = 33'(DUTY_MAX);
    localparam logic signed [31:0] DutyMax   = 32'(DUTY_MAX);
    localparam logic signed [31:0] Step      = 32'(SLEW_STEP);
    localparam logic signed [31:0] StallMin  = 32'(STALL_MIN);
    localparam logic [31:0]        PrescLast = 32'(UPDATE_DIV - 1);
    localparam logic [31:0]        DeadLast  = 32'(DEADTIME - 1);
    localparam logic [31:0]        StallLim  = 32'(STALL_TICKS);

    function automatic logic [1:0] dir_of(input logic signed [31:0] v);
        if (v == '0) begin
            return DirNone;
        end else if (v[31]) begin
            return DirNeg;
        end else begin
            return DirPos;
        end
    endfunction

    state_e                state_q, state_d;
    logic signed [31:0]    duty_out_q, duty_out_d;
    logic                  joint_enable_q, joint_enable_d;
    logic                  fault_q, fault_d;
    logic [1:0]            last_dir_q, last_dir_d;
    logic [31:0]           presc_q, presc_d;
    logic [31:0]           stall_q, stall_d;
    logic [31:0]           dead_q, dead_d;
    logic [ENC_BITS-1:0]   enc_snap_q, enc_snap_d;

    logic signed [32:0]    cmd_ext;
    logic signed [31:0]    target;
    logic                  tick;
    logic signed [31:0]    duty_abs;
    logic signed [31:0]    rev_abs;
    logic signed [31:0]    rev_duty;
    logic signed [31:0]    diff;
    logic signed [31:0]    slew_duty;
    logic [1:0]            tgt_dir;
    logic [1:0]            duty_dir;
    logic                  reversal;
    logic                  dead_entry;
    logic                  stall_cond;
    logic [31:0]           stall_next;

    // Clamp the command in 33 bits so the most negative cmd cannot wrap
    always_comb begin
        cmd_ext = 33'(cmd);
        if (cmd_ext > DutyMax33) begin
            target = DutyMax;
        end else if (cmd_ext < -DutyMax33) begin
            target = -DutyMax;
        end else begin
            target = cmd;
        end
    end

    assign tick = (presc_q == PrescLast);

    // Candidate duty values for a reversal step (toward zero) and a normal slew step
    always_comb begin
        duty_abs = duty_out_q[31] ? -duty_out_q : duty_out_q;
        if (duty_abs > Step) begin
            rev_abs = duty_abs - Step;
        end else begin
            rev_abs = '0;
        end
        rev_duty = duty_out_q[31] ? -rev_abs : rev_abs;

        diff = target - duty_out_q;
        if (diff > Step) begin
            slew_duty = duty_out_q + Step;
        end else if (diff < -Step) begin
            slew_duty = duty_out_q - Step;
        end else begin
            slew_duty = target;
        end
    end

    // Rule qualifiers for the RUN tick decision and stall supervision
    always_comb begin
        tgt_dir    = dir_of(target);
        duty_dir   = dir_of(duty_out_q);
        reversal   = (duty_dir != DirNone) && (tgt_dir != DirNone) && (tgt_dir != duty_dir);
        dead_entry = (duty_dir == DirNone) && (tgt_dir != DirNone) &&
                     (last_dir_q != DirNone) && (tgt_dir != last_dir_q);
        stall_cond = (duty_abs >= StallMin) && (enc_pos == enc_snap_q);
        stall_next = stall_cond ? (stall_q + 32'd1) : '0;
    end

    // Next-state and registered-output logic of the sequencer
    always_comb begin
        state_d        = state_q;
        duty_out_d     = duty_out_q;
        joint_enable_d = joint_enable_q;
        fault_d        = fault_q;
        last_dir_d     = last_dir_q;
        stall_d        = stall_q;
        dead_d         = dead_q;
        presc_d        = tick ? '0 : (presc_q + 32'd1);
        enc_snap_d     = tick ? enc_pos : enc_snap_q;

        unique case (state_q)
            StIdle: begin
                duty_out_d     = '0;
                joint_enable_d = 1'b0;
                fault_d        = 1'b0;
                if (enable_in) begin
                    state_d        = StRun;
                    joint_enable_d = 1'b1;
                    stall_d        = '0;
                end
            end

            StRun: begin
                if (!enable_in) begin
                    state_d        = StIdle;
                    duty_out_d     = '0;
                    joint_enable_d = 1'b0;
                    last_dir_d     = DirNone;
                end else if (tick) begin
                    // Stall wins over any slew action in the same tick
                    if (stall_next >= StallLim) begin
                        state_d        = StFault;
                        duty_out_d     = '0;
                        joint_enable_d = 1'b0;
                        fault_d        = 1'b1;
                        stall_d        = '0;
                    end else begin
                        stall_d = stall_next;
                        if (reversal) begin
                            duty_out_d = rev_duty;
                        end else if (dead_entry) begin
                            state_d = StDead;
                            dead_d  = '0;
                        end else begin
                            duty_out_d = slew_duty;
                            if (slew_duty != '0) begin
                                last_dir_d = dir_of(slew_duty);
                            end
                        end
                    end
                end
            end

            StDead: begin
                duty_out_d = '0;
                if (!enable_in) begin
                    state_d        = StIdle;
                    joint_enable_d = 1'b0;
                    last_dir_d     = DirNone;
                end else if (dead_q == DeadLast) begin
                    state_d    = StRun;
                    last_dir_d = tgt_dir;
                    stall_d    = '0;
                end else begin
                    dead_d = dead_q + 32'd1;
                end
            end

            StFault: begin
                duty_out_d     = '0;
                joint_enable_d = 1'b0;
                fault_d        = 1'b1;
                if (!enable_in) begin
                    state_d    = StIdle;
                    fault_d    = 1'b0;
                    last_dir_d = DirNone;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            duty_out_q     <= '0;
            joint_enable_q <= 1'b0;
            fault_q        <= 1'b0;
            last_dir_q     <= DirNone;
            presc_q        <= '0;
            stall_q        <= '0;
            dead_q         <= '0;
            enc_snap_q     <= '0;
        end else begin
            state_q        <= state_d;
            duty_out_q     <= duty_out_d;
            joint_enable_q <= joint_enable_d;
            fault_q        <= fault_d;
            last_dir_q     <= last_dir_d;
            presc_q        <= presc_d;
            stall_q        <= stall_d;
            dead_q         <= dead_d;
            enc_snap_q     <= enc_snap_d;
        end
    end

    assign duty_out     = duty_out_q;
    assign joint_enable = joint_enable_q;
    assign fault        = fault_q;
    assign state        = state_q;

endmodule
